// File: rtl/game_pkg.sv
// Shared constants, state encoding and position helpers for the sprite motion sequencer.
package game_pkg;

    localparam int unsigned POS_W     = 16;
    localparam int unsigned SCORE_W   = 8;
    localparam int unsigned HD        = 640;
    localparam int unsigned VD        = 480;
    localparam int unsigned SPRITE    = 16;
    localparam int unsigned PLANET_X0 = 320;
    localparam int unsigned PLANET_Y0 = 64;
    localparam int unsigned SHIP_X0   = 312;
    localparam int unsigned SHIP_Y0   = VD - 2 * SPRITE;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLANET  = 2'd1,
        SHIP    = 2'd2,
        COLLIDE = 2'd3
    } motion_state_t;

    typedef struct packed {
        logic [POS_W-1:0] x;
        logic [POS_W-1:0] y;
    } pos_t;

    // Move one step toward 0 or toward bound, clamping at either end without wrapping.
    function automatic logic [POS_W-1:0] step_clamp(
        input logic [POS_W-1:0] pos,
        input logic [POS_W-1:0] step,
        input logic [POS_W-1:0] bound,
        input logic             dec
    );
        logic [POS_W-1:0] res;
        if (dec) begin
            res = (pos <= step) ? '0 : pos - step;
        end else begin
            res = (pos + step >= bound) ? bound : pos + step;
        end
        return res;
    endfunction

    // Unsigned distance between two coordinates.
    function automatic logic [POS_W-1:0] abs_diff(
        input logic [POS_W-1:0] a,
        input logic [POS_W-1:0] b
    );
        return (a >= b) ? a - b : b - a;
    endfunction

endpackage

// File: rtl/axis_bounce.sv
// Next position and direction for one bouncing axis; a flip and a clamp happen together.
module axis_bounce
    import game_pkg::*;
#(
    parameter int unsigned BOUND = HD - SPRITE,
    parameter int unsigned STEP  = 1
) (
    input  logic [POS_W-1:0] pos_i,
    input  logic             rev_i,
    output logic [POS_W-1:0] next_pos_c,
    output logic             next_rev_c
);

    localparam logic [POS_W-1:0] BOUND_W = POS_W'(BOUND);
    localparam logic [POS_W-1:0] STEP_W  = POS_W'(STEP);

    // Advance in the current direction, reversing at whichever edge is reached.
    always_comb begin
        next_pos_c = pos_i;
        next_rev_c = rev_i;
        if (!rev_i) begin
            if (pos_i + STEP_W >= BOUND_W) begin
                next_pos_c = BOUND_W;
                next_rev_c = 1'b1;
            end else begin
                next_pos_c = pos_i + STEP_W;
            end
        end else begin
            if (pos_i <= STEP_W) begin
                next_pos_c = '0;
                next_rev_c = 1'b0;
            end else begin
                next_pos_c = pos_i - STEP_W;
            end
        end
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite motion sequencer: bounces the planet, steers the ship, flags collisions.
// Optional build macro SPRITE_SCORE_EN adds a saturating score and resets the planet on a hit.
module sprite_motion_ctrl
    import game_pkg::*;
#(
    parameter int unsigned PLANET_STEP = 1,
    parameter int unsigned SHIP_STEP   = 2,
    parameter int unsigned FRAME_DIV   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vsync,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_up,
    input  logic               btn_down,
    output logic [POS_W-1:0]   x_planet,
    output logic [POS_W-1:0]   y_planet,
    output logic [POS_W-1:0]   x_ship,
    output logic [POS_W-1:0]   y_ship,
    output logic               h_reverse,
    output logic               v_reverse,
    output logic               hit,
    output logic               busy
`ifdef SPRITE_SCORE_EN
    ,
    output logic [SCORE_W-1:0] score
`endif
);

    localparam int unsigned      CNT_W  = $clog2(FRAME_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [POS_W-1:0] X_MAX  = POS_W'(HD - SPRITE);
    localparam logic [POS_W-1:0] Y_MAX  = POS_W'(VD - SPRITE);
    localparam logic [POS_W-1:0] S_STEP = POS_W'(SHIP_STEP);
    localparam logic [POS_W-1:0] SPR_W  = POS_W'(SPRITE);
    localparam pos_t PLANET_RST = '{x: POS_W'(PLANET_X0), y: POS_W'(PLANET_Y0)};
    localparam pos_t SHIP_RST   = '{x: POS_W'(SHIP_X0),   y: POS_W'(SHIP_Y0)};

    motion_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             vsync_q;
    pos_t             planet_q, planet_d;
    pos_t             ship_q, ship_d;
    logic             hrev_q, hrev_d;
    logic             vrev_q, vrev_d;
    logic             hit_q, hit_d;
    logic             busy_q, busy_d;
`ifdef SPRITE_SCORE_EN
    logic [SCORE_W-1:0] score_q, score_d;
`endif

    logic             tick_c;
    logic             overlap_c;
    logic [POS_W-1:0] px_next_c, py_next_c;
    logic             hrev_next_c, vrev_next_c;

    assign tick_c    = vsync & ~vsync_q;
    assign overlap_c = (abs_diff(planet_q.x, ship_q.x) < SPR_W) &&
                       (abs_diff(planet_q.y, ship_q.y) < SPR_W);

    axis_bounce #(.BOUND(HD - SPRITE), .STEP(PLANET_STEP)) u_bounce_x (
        .pos_i      (planet_q.x),
        .rev_i      (hrev_q),
        .next_pos_c (px_next_c),
        .next_rev_c (hrev_next_c)
    );

    axis_bounce #(.BOUND(VD - SPRITE), .STEP(PLANET_STEP)) u_bounce_y (
        .pos_i      (planet_q.y),
        .rev_i      (vrev_q),
        .next_pos_c (py_next_c),
        .next_rev_c (vrev_next_c)
    );

    // Edge detector for the frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vsync_q <= 1'b0;
        else        vsync_q <= vsync;
    end

    // Sequencer state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            planet_q <= PLANET_RST;
            ship_q   <= SHIP_RST;
            hrev_q   <= 1'b0;
            vrev_q   <= 1'b0;
            hit_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef SPRITE_SCORE_EN
            score_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            planet_q <= planet_d;
            ship_q   <= ship_d;
            hrev_q   <= hrev_d;
            vrev_q   <= vrev_d;
            hit_q    <= hit_d;
            busy_q   <= busy_d;
`ifdef SPRITE_SCORE_EN
            score_q  <= score_d;
`endif
        end
    end

    // Next-state and datapath updates; each sequence step touches only its own sprite.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        planet_d = planet_q;
        ship_d   = ship_q;
        hrev_d   = hrev_q;
        vrev_d   = vrev_q;
        hit_d    = 1'b0;
`ifdef SPRITE_SCORE_EN
        score_d  = score_q;
`endif
        case (state_q)
            IDLE: begin
                if (tick_c) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = PLANET;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            PLANET: begin
                planet_d.x = px_next_c;
                planet_d.y = py_next_c;
                hrev_d     = hrev_next_c;
                vrev_d     = vrev_next_c;
                state_d    = SHIP;
            end
            SHIP: begin
                if (btn_left ^ btn_right) begin
                    ship_d.x = step_clamp(ship_q.x, S_STEP, X_MAX, btn_left);
                end
                if (btn_up ^ btn_down) begin
                    ship_d.y = step_clamp(ship_q.y, S_STEP, Y_MAX, btn_up);
                end
                state_d = COLLIDE;
            end
            COLLIDE: begin
                hit_d   = overlap_c;
                state_d = IDLE;
`ifdef SPRITE_SCORE_EN
                if (overlap_c) begin
                    planet_d = PLANET_RST;
                    hrev_d   = 1'b0;
                    vrev_d   = 1'b0;
                    if (score_q != '1) score_d = score_q + SCORE_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign x_planet  = planet_q.x;
    assign y_planet  = planet_q.y;
    assign x_ship    = ship_q.x;
    assign y_ship    = ship_q.y;
    assign h_reverse = hrev_q;
    assign v_reverse = vrev_q;
    assign hit       = hit_q;
    assign busy      = busy_q;
`ifdef SPRITE_SCORE_EN
    assign score     = score_q;
`endif

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Scoreboard bench for sprite_motion_ctrl: one instance at FRAME_DIV=1, one at FRAME_DIV=3.
module tb_sprite_motion_ctrl;

    localparam int XMAX  = 624;
    localparam int YMAX  = 464;
    localparam int PSTEP = 1;
    localparam int SSTEP = 2;

    typedef struct packed {
        logic [15:0] xp;
        logic [15:0] yp;
        logic [15:0] xs;
        logic [15:0] ys;
        logic        h;
        logic        v;
        logic        hit;
        logic [7:0]  score;
    } exp_t;

    logic clk, rst_n1, rst_n3, vsync;
    logic btn_l, btn_r, btn_u, btn_d;
    logic [15:0] xp1, yp1, xs1, ys1, xp3, yp3, xs3, ys3;
    logic hr1, vr1, hit1, busy1, hr3, vr3, hit3, busy3;
`ifdef SPRITE_SCORE_EN
    logic [7:0] score1, score3;
`endif

    int vecs = 0;
    int errs = 0;
    int m_xp, m_yp, m_xs, m_ys, m_score, m_hits, obs_hits;
    bit m_h, m_v;
    exp_t sb[$];

    sprite_motion_ctrl #(.PLANET_STEP(1), .SHIP_STEP(2), .FRAME_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n1), .vsync(vsync),
        .btn_left(btn_l), .btn_right(btn_r), .btn_up(btn_u), .btn_down(btn_d),
        .x_planet(xp1), .y_planet(yp1), .x_ship(xs1), .y_ship(ys1),
        .h_reverse(hr1), .v_reverse(vr1), .hit(hit1), .busy(busy1)
`ifdef SPRITE_SCORE_EN
        , .score(score1)
`endif
    );

    sprite_motion_ctrl #(.PLANET_STEP(1), .SHIP_STEP(2), .FRAME_DIV(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n3), .vsync(vsync),
        .btn_left(btn_l), .btn_right(btn_r), .btn_up(btn_u), .btn_down(btn_d),
        .x_planet(xp3), .y_planet(yp3), .x_ship(xs3), .y_ship(ys3),
        .h_reverse(hr3), .v_reverse(vr3), .hit(hit3), .busy(busy3)
`ifdef SPRITE_SCORE_EN
        , .score(score3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t sample1();
        exp_t g;
        g.xp = xp1; g.yp = yp1; g.xs = xs1; g.ys = ys1;
        g.h = hr1; g.v = vr1; g.hit = hit1;
`ifdef SPRITE_SCORE_EN
        g.score = score1;
`else
        g.score = 8'd0;
`endif
        return g;
    endfunction

    task automatic model_reset();
        m_xp = 320; m_yp = 64; m_xs = 312; m_ys = 448;
        m_h = 1'b0; m_v = 1'b0; m_score = 0;
    endtask

    // Reference behaviour for one update sequence.
    task automatic model_step(input bit l, input bit r, input bit u, input bit d, output exp_t e);
        bit hit_m;
        if (!m_h) begin
            if (m_xp + PSTEP >= XMAX) begin m_xp = XMAX; m_h = 1'b1; end
            else m_xp = m_xp + PSTEP;
        end else begin
            if (m_xp <= PSTEP) begin m_xp = 0; m_h = 1'b0; end
            else m_xp = m_xp - PSTEP;
        end
        if (!m_v) begin
            if (m_yp + PSTEP >= YMAX) begin m_yp = YMAX; m_v = 1'b1; end
            else m_yp = m_yp + PSTEP;
        end else begin
            if (m_yp <= PSTEP) begin m_yp = 0; m_v = 1'b0; end
            else m_yp = m_yp - PSTEP;
        end
        if (l && !r) m_xs = (m_xs - SSTEP < 0) ? 0 : m_xs - SSTEP;
        if (r && !l) m_xs = (m_xs + SSTEP > XMAX) ? XMAX : m_xs + SSTEP;
        if (u && !d) m_ys = (m_ys - SSTEP < 0) ? 0 : m_ys - SSTEP;
        if (d && !u) m_ys = (m_ys + SSTEP > YMAX) ? YMAX : m_ys + SSTEP;
        hit_m = ((m_xp > m_xs ? m_xp - m_xs : m_xs - m_xp) < 16) &&
                ((m_yp > m_ys ? m_yp - m_ys : m_ys - m_yp) < 16);
        if (hit_m) m_hits++;
`ifdef SPRITE_SCORE_EN
        if (hit_m) begin
            if (m_score < 255) m_score++;
            m_xp = 320; m_yp = 64; m_h = 1'b0; m_v = 1'b0;
        end
`endif
        e.xp = 16'(m_xp); e.yp = 16'(m_yp); e.xs = 16'(m_xs); e.ys = 16'(m_ys);
        e.h = m_h; e.v = m_v; e.hit = hit_m; e.score = 8'(m_score);
    endtask

    // One vsync edge on dut1: push the expectation, then pop it when the sequence finishes.
    task automatic run_frame(input bit l, input bit r, input bit u, input bit d);
        exp_t e, g, q;
        int   bcnt;
        bit   got, pulse_bad;
        @(negedge clk);
        btn_l = l; btn_r = r; btn_u = u; btn_d = d;
        model_step(l, r, u, d, e);
        sb.push_back(e);
        vsync = 1'b1;
        bcnt = 0; got = 1'b0; pulse_bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) vsync = 1'b0;
            if (busy1) begin
                bcnt++;
            end else if (bcnt > 0 && !got) begin
                got = 1'b1;
                g = sample1();
                q = sb.pop_front();
                vecs++;
                if (g.hit) obs_hits++;
                if (g !== q) begin
                    errs++;
                    $display("FAIL frame_result: got %h expected %h", g, q);
                end
            end else if (got && hit1 !== 1'b0) begin
                pulse_bad = 1'b1;
            end
        end
        vecs++;
        if (bcnt != 3 || !got || pulse_bad) begin
            errs++;
            $display("FAIL busy_hit_timing: busy cycles %0d (expected 3), done %0d, long hit %0d",
                     bcnt, got, pulse_bad);
            if (!got && sb.size() > 0) void'(sb.pop_front());
        end
    endtask

    task automatic test_reset();
        exp_t g, q;
        repeat (3) @(negedge clk);
        model_reset();
        q = '{xp: 16'd320, yp: 16'd64, xs: 16'd312, ys: 16'd448, h: 1'b0, v: 1'b0, hit: 1'b0, score: 8'd0};
        g = sample1();
        vecs++;
        if (g !== q || busy1 !== 1'b0) begin
            errs++;
            $display("FAIL reset_values: got %h busy %b expected %h busy 0", g, busy1, q);
        end
        rst_n1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            g = sample1();
            vecs++;
            if (g !== q || busy1 !== 1'b0) begin
                errs++;
                $display("FAIL idle_after_reset: got %h busy %b expected %h busy 0", g, busy1, q);
            end
        end
    endtask

    task automatic test_free_run();
        for (int f = 0; f < 10; f++) run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (xp1 !== 16'd330 || yp1 !== 16'd74 || hr1 !== 1'b0 || vr1 !== 1'b0) begin
            errs++;
            $display("FAIL free_run_10: got x=%0d y=%0d h=%b v=%b expected x=330 y=74 h=0 v=0",
                     xp1, yp1, hr1, vr1);
        end
    endtask

    task automatic test_bounce();
        bit over;
        over = 1'b0;
        for (int f = 0; f < 400 && m_xp != XMAX; f++) begin
            run_frame(1'b0, 1'b0, 1'b0, 1'b0);
            if (xp1 > 16'(XMAX)) over = 1'b1;
        end
        vecs++;
        if (xp1 !== 16'(XMAX) || hr1 !== 1'b1) begin
            errs++;
            $display("FAIL right_edge: got x=%0d h=%b expected x=624 h=1", xp1, hr1);
        end
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (xp1 !== 16'd623 || hr1 !== 1'b1) begin
            errs++;
            $display("FAIL right_rebound: got x=%0d h=%b expected x=623 h=1", xp1, hr1);
        end
        for (int f = 0; f < 500 && m_yp != YMAX; f++) begin
            run_frame(1'b0, 1'b0, 1'b0, 1'b0);
            if (yp1 > 16'(YMAX) || xp1 > 16'(XMAX)) over = 1'b1;
        end
        vecs++;
        if (yp1 !== 16'(YMAX) || vr1 !== 1'b1) begin
            errs++;
            $display("FAIL bottom_edge: got y=%0d v=%b expected y=464 v=1", yp1, vr1);
        end
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (yp1 !== 16'd463 || over) begin
            errs++;
            $display("FAIL bottom_rebound: got y=%0d out_of_range=%b expected y=463 out_of_range=0",
                     yp1, over);
        end
    endtask

    task automatic test_ship_clamp();
        for (int f = 0; f < 200; f++) run_frame(1'b1, 1'b0, 1'b0, 1'b0);
        vecs++;
        if (xs1 !== 16'd0) begin
            errs++;
            $display("FAIL ship_left_clamp: got x=%0d expected 0", xs1);
        end
        for (int f = 0; f < 5; f++) run_frame(1'b1, 1'b1, 1'b0, 1'b0);
        vecs++;
        if (xs1 !== 16'd0) begin
            errs++;
            $display("FAIL ship_lr_conflict: got x=%0d expected 0", xs1);
        end
        for (int f = 0; f < 12; f++) run_frame(1'b0, 1'b0, 1'b0, 1'b1);
        vecs++;
        if (ys1 !== 16'(YMAX)) begin
            errs++;
            $display("FAIL ship_down_clamp: got y=%0d expected 464", ys1);
        end
    endtask

    // Steer the ship to sit a fixed distance left of the planet, first at 16 then at 15.
    task automatic test_collision();
        int off, dx, dy;
        m_hits = 0; obs_hits = 0;
        for (int ph = 0; ph < 2; ph++) begin
            off = (ph == 0) ? 16 : 15;
            for (int f = 0; f < 250; f++) begin
                dx = (m_xp - off) - m_xs;
                dy = m_yp - m_ys;
                run_frame(dx < -1, dx > 1, dy < -1, dy > 1);
            end
        end
        vecs++;
        if (obs_hits != m_hits || m_hits == 0) begin
            errs++;
            $display("FAIL hit_count: got %0d pulses expected %0d (nonzero)", obs_hits, m_hits);
        end
    endtask

    task automatic test_frame_div3();
        int  bcyc, rises;
        bit  prev, seen;
        btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
        @(negedge clk);
        rst_n3 = 1'b1;
        bcyc = 0; rises = 0; prev = 1'b0;
        for (int e = 0; e < 9; e++) begin
            @(negedge clk);
            vsync = 1'b1;
            for (int k = 0; k < 7; k++) begin
                @(negedge clk);
                if (k == 0) vsync = 1'b0;
                if (busy3) bcyc++;
                if (busy3 && !prev) rises++;
                prev = busy3;
            end
        end
        vecs++;
        if (rises != 3 || bcyc != 9) begin
            errs++;
            $display("FAIL div3_updates: got %0d updates %0d busy cycles expected 3 and 9", rises, bcyc);
        end
        vecs++;
        if (xp3 !== 16'd323 || yp3 !== 16'd67) begin
            errs++;
            $display("FAIL div3_position: got x=%0d y=%0d expected x=323 y=67", xp3, yp3);
        end
        btn_l = 1'b1;
        seen = 1'b0;
        for (int e = 0; e < 3 && !seen; e++) begin
            @(negedge clk);
            vsync = 1'b1;
            for (int k = 0; k < 4 && !seen; k++) begin
                @(negedge clk);
                if (k == 0) vsync = 1'b0;
                if (busy3) seen = 1'b1;
            end
            if (!seen) repeat (3) @(negedge clk);
        end
        vecs++;
        if (!seen) begin
            errs++;
            $display("FAIL div3_start_timeout: got no busy expected busy within 3 edges");
        end else begin
            @(negedge clk);
            rst_n3 = 1'b0;
            #1;
            if (xp3 !== 16'd320 || yp3 !== 16'd64 || xs3 !== 16'd312 || ys3 !== 16'd448 ||
                hr3 !== 1'b0 || vr3 !== 1'b0 || busy3 !== 1'b0 || hit3 !== 1'b0) begin
                errs++;
                $display("FAIL midseq_reset: got %0d,%0d %0d,%0d h%b v%b busy%b hit%b expected 320,64 312,448 all 0",
                         xp3, yp3, xs3, ys3, hr3, vr3, busy3, hit3);
            end
        end
        repeat (2) @(negedge clk);
        rst_n3 = 1'b1;
        prev = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (hit3 !== 1'b0 || busy3 !== 1'b0 || xs3 !== 16'd312) prev = 1'b1;
        end
        vecs++;
        if (prev) begin
            errs++;
            $display("FAIL post_reset_quiet: got activity after reset expected none");
        end
        btn_l = 1'b0;
    endtask

    initial begin
        rst_n1 = 1'b0; rst_n3 = 1'b0; vsync = 1'b0;
        btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
        test_reset();
        test_free_run();
        test_bounce();
        test_ship_clamp();
        test_collision();
        test_frame_div3();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
